// File: rtl/fixed_pkg.sv
// Shared constants, FSM state encoding and packed BCD types for the
// fixed-point to BCD converter.
package fixed_pkg;

   localparam int unsigned INT_W       = 15;
   localparam int unsigned FRAC_W      = 10;
   localparam int unsigned INT_DIGITS  = 5;
   localparam int unsigned FRAC_DIGITS = 3;
   localparam int unsigned CNT_W       = $clog2(INT_W);

   typedef enum logic [1:0] {
      IDLE,
      INT,
      FRAC,
      DONE
   } state_t;

   typedef logic [4*INT_DIGITS-1:0]  int_bcd_t;
   typedef logic [4*FRAC_DIGITS-1:0] frac_bcd_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   always_comb begin
      nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
   end

endmodule

// File: rtl/fixed_to_bcd.sv
// Iterative converter: integer magnitude via double-dabble, fraction via
// repeated multiply-by-10 (truncated). One word in flight, valid/ready input.
module fixed_to_bcd
   import fixed_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_neg,
   input  logic                     in_frac,
   input  logic [INT_W-1:0]         in_int,
   input  logic [FRAC_W-1:0]        in_fbits,
   output logic                     out_valid,
   output logic                     out_neg,
   output logic                     out_frac,
   output logic [4*INT_DIGITS-1:0]  int_bcd,
   output logic [4*FRAC_DIGITS-1:0] frac_bcd
);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [INT_W-1:0]  shift_q, shift_d;
   int_bcd_t          bcd_q, bcd_adj, bcd_d;
   logic [FRAC_W-1:0] f_q, f_d;
   logic [FRAC_W+3:0] prod;
   frac_bcd_t         fdig_q, fdig_d;
   logic              neg_q, frac_flag_q;

   logic              in_ready_q, out_valid_q, out_neg_q, out_frac_q;
   int_bcd_t          int_bcd_q;
   frac_bcd_t         frac_bcd_q;

   for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nib_i (bcd_q[4*g +: 4]),
         .nib_o (bcd_adj[4*g +: 4])
      );
   end

   always_comb begin
      {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
      prod             = {4'b0000, f_q} * 14'd10;
      f_d              = prod[FRAC_W-1:0];
      fdig_d           = {fdig_q[4*FRAC_DIGITS-5:0], prod[FRAC_W+3:FRAC_W]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         bcd_q       <= '0;
         f_q         <= '0;
         fdig_q      <= '0;
         neg_q       <= 1'b0;
         frac_flag_q <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_neg_q   <= 1'b0;
         out_frac_q  <= 1'b0;
         int_bcd_q   <= '0;
         frac_bcd_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               out_valid_q <= 1'b0;
               if (in_valid) begin
                  shift_q     <= in_int;
                  f_q         <= in_fbits;
                  neg_q       <= in_neg;
                  frac_flag_q <= in_frac;
                  bcd_q       <= '0;
                  fdig_q      <= '0;
                  cnt_q       <= CNT_W'(INT_W - 1);
                  in_ready_q  <= 1'b0;
                  state_q     <= INT;
               end
            end
            INT: begin
               bcd_q   <= bcd_d;
               shift_q <= shift_d;
               if (cnt_q == '0) begin
                  cnt_q   <= CNT_W'(FRAC_DIGITS - 1);
                  state_q <= FRAC;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FRAC: begin
               f_q    <= f_d;
               fdig_q <= fdig_d;
               if (cnt_q == '0) begin
                  // Results load on the DONE entry edge, so the last digit comes from fdig_d.
                  int_bcd_q   <= bcd_q;
                  frac_bcd_q  <= fdig_d;
                  out_neg_q   <= neg_q;
                  out_frac_q  <= frac_flag_q;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_neg   = out_neg_q;
   assign out_frac  = out_frac_q;
   assign int_bcd   = int_bcd_q;
   assign frac_bcd  = frac_bcd_q;

endmodule

// File: tb/tb_fixed_to_bcd.sv
// Directed bench for fixed_to_bcd: reset, conversions, truncation, busy
// back-to-back acceptance and reset during a conversion.
module tb_fixed_to_bcd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_neg;
   logic        in_frac;
   logic [14:0] in_int;
   logic [9:0]  in_fbits;
   logic        out_valid;
   logic        out_neg;
   logic        out_frac;
   logic [19:0] int_bcd;
   logic [11:0] frac_bcd;

   int total = 0;
   int bad   = 0;

   fixed_to_bcd dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_neg    (in_neg),
      .in_frac   (in_frac),
      .in_int    (in_int),
      .in_fbits  (in_fbits),
      .out_valid (out_valid),
      .out_neg   (out_neg),
      .out_frac  (out_frac),
      .int_bcd   (int_bcd),
      .frac_bcd  (frac_bcd)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] m_int(input int v);
      logic [19:0] r;
      r = '0;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [11:0] m_frac(input int f);
      int t;
      t = (f * 1000) / 1024;
      return {4'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
   endfunction

   // Waits (bounded) for in_ready, presents one word for one accepting edge,
   // then counts cycles after acceptance until out_valid (cycle 1 = first after accept).
   task automatic send_and_wait(input logic [14:0] i, input logic [9:0] f,
                                input logic neg, input logic fr,
                                output int cyc, output bit seen);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      in_int   = i;
      in_fbits = f;
      in_neg   = neg;
      in_frac  = fr;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0; in_neg = 1'b0; in_frac = 1'b0; in_int = '0; in_fbits = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({in_ready, out_valid, out_neg, out_frac} !== 4'b1000) begin
         bad++;
         $display("FAIL reset_ctrl got rdy/vld/neg/frac=%b required 1000",
                  {in_ready, out_valid, out_neg, out_frac});
      end
      total++;
      if ({int_bcd, frac_bcd} !== 32'h00000_000) begin
         bad++;
         $display("FAIL reset_bcd got %h_%h required 00000_000", int_bcd, frac_bcd);
      end
   endtask

   task automatic test_basic;
      int cyc; bit seen;
      send_and_wait(15'd12345, 10'd512, 1'b0, 1'b1, cyc, seen);
      total++;
      if (!seen || cyc != 19) begin
         bad++;
         $display("FAIL basic_latency got seen=%0d cyc=%0d required seen=1 cyc=19", seen, cyc);
      end
      total++;
      if ({int_bcd, frac_bcd} !== 32'h12345_500) begin
         bad++;
         $display("FAIL basic_bcd got %h_%h required 12345_500", int_bcd, frac_bcd);
      end
      total++;
      if ({out_neg, out_frac} !== 2'b01) begin
         bad++;
         $display("FAIL basic_flags got neg/frac=%b required 01", {out_neg, out_frac});
      end
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_strobe_width got out_valid=%b required 0", out_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({int_bcd, frac_bcd, out_frac} !== {32'h12345_500, 1'b1}) begin
         bad++;
         $display("FAIL basic_hold got %h_%h frac=%b required 12345_500 frac=1",
                  int_bcd, frac_bcd, out_frac);
      end
   endtask

   task automatic test_max;
      int cyc; bit seen;
      send_and_wait(15'd32767, 10'd1023, 1'b1, 1'b0, cyc, seen);
      total++;
      if (!seen || {int_bcd, frac_bcd} !== 32'h32767_999) begin
         bad++;
         $display("FAIL max_bcd got seen=%0d %h_%h required 32767_999", seen, int_bcd, frac_bcd);
      end
      total++;
      if ({out_neg, out_frac} !== 2'b10) begin
         bad++;
         $display("FAIL max_flags got neg/frac=%b required 10", {out_neg, out_frac});
      end
   endtask

   task automatic test_trunc;
      int cyc; bit seen;
      send_and_wait(15'd0, 10'd102, 1'b0, 1'b1, cyc, seen);
      total++;
      if (!seen || {int_bcd, frac_bcd} !== 32'h00000_099) begin
         bad++;
         $display("FAIL trunc_bcd got seen=%0d %h_%h required 00000_099", seen, int_bcd, frac_bcd);
      end
   endtask

   task automatic test_digits;
      int cyc; bit seen;
      send_and_wait(15'd0, 10'd0, 1'b0, 1'b0, cyc, seen);
      total++;
      if (!seen || {int_bcd, frac_bcd, out_neg, out_frac} !== {32'h00000_000, 2'b00}) begin
         bad++;
         $display("FAIL zero_bcd got seen=%0d %h_%h required 00000_000", seen, int_bcd, frac_bcd);
      end
      send_and_wait(15'd9, 10'd256, 1'b0, 1'b0, cyc, seen);
      total++;
      if (!seen || {int_bcd, frac_bcd, out_frac} !== {32'h00009_250, 1'b0}) begin
         bad++;
         $display("FAIL nofrac_flag_bcd got seen=%0d %h_%h frac=%b required 00009_250 frac=0",
                  seen, int_bcd, frac_bcd, out_frac);
      end
      send_and_wait(15'd9999, 10'd1000, 1'b1, 1'b1, cyc, seen);
      total++;
      if (!seen || {int_bcd, frac_bcd} !== 32'h09999_976) begin
         bad++;
         $display("FAIL carry_bcd got seen=%0d %h_%h required 09999_976", seen, int_bcd, frac_bcd);
      end
      send_and_wait(15'd10, 10'd1, 1'b0, 1'b1, cyc, seen);
      total++;
      if (!seen || {int_bcd, frac_bcd} !== 32'h00010_000) begin
         bad++;
         $display("FAIL ten_bcd got seen=%0d %h_%h required 00010_000", seen, int_bcd, frac_bcd);
      end
   endtask

   // in_valid held high with a new word every cycle: accepts land on edges 0, 20, 40.
   task automatic test_back_to_back;
      int n;
      logic [14:0] wi [0:59];
      logic [9:0]  wf [0:59];
      bit exp_v;
      for (int k = 0; k < 60; k++) begin
         wi[k] = 15'((k * 1337 + 5) % 32768);
         wf[k] = 10'((k * 97 + 3) % 1024);
      end
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 60; k++) begin
         in_valid = 1'b1;
         in_int   = wi[k];
         in_fbits = wf[k];
         in_neg   = k[0];
         in_frac  = k[1];
         @(posedge clk);
         #1;
         exp_v = (k % 20 == 18);
         total++;
         if (out_valid !== exp_v) begin
            bad++;
            $display("FAIL b2b_valid edge=%0d got %b required %b", k, out_valid, exp_v);
         end
         if (exp_v) begin
            total++;
            if ({int_bcd, frac_bcd} !== {m_int(int'(wi[k-18])), m_frac(int'(wf[k-18]))}) begin
               bad++;
               $display("FAIL b2b_bcd edge=%0d got %h_%h required %h_%h", k, int_bcd, frac_bcd,
                        m_int(int'(wi[k-18])), m_frac(int'(wf[k-18])));
            end
            total++;
            if ({out_neg, out_frac} !== {wi[0][0] & 1'b0 | (k - 18) % 2 == 1, (k - 18) % 4 >= 2}) begin
               bad++;
               $display("FAIL b2b_flags edge=%0d got %b%b", k, out_neg, out_frac);
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      int cyc; bit seen;
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1; in_int = 15'd4321; in_fbits = 10'd768; in_neg = 1'b1; in_frac = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid, out_neg, out_frac, int_bcd, frac_bcd} !== {4'b1000, 32'h0}) begin
         bad++;
         $display("FAIL midreset_values got rdy/vld/neg/frac=%b bcd=%h_%h required 1000 00000_000",
                  {in_ready, out_valid, out_neg, out_frac}, int_bcd, frac_bcd);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL midreset_abort got out_valid seen=%0d required 0", seen);
      end
      send_and_wait(15'd4321, 10'd768, 1'b0, 1'b1, cyc, seen);
      total++;
      if (!seen || cyc != 19 || {int_bcd, frac_bcd} !== 32'h04321_750) begin
         bad++;
         $display("FAIL midreset_after got seen=%0d cyc=%0d %h_%h required 1 19 04321_750",
                  seen, cyc, int_bcd, frac_bcd);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_max;
      test_trunc;
      test_digits;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout global bound reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/fixed_to_bcd.md
Name: fixed_to_bcd

Overview:
- Sequential converter directly downstream of the sign/fraction split stage.
- Takes a registered magnitude: 15-bit integer part, 10-bit fraction part, sign flag and fraction-present flag.
- Produces 5 packed-BCD integer digits and 3 packed-BCD fraction digits for the display/readout stage.
- Integer path uses iterative double-dabble; fraction path uses iterative multiply-by-10. One conversion in flight at a time, under a valid/ready handshake.

Parameters:
- INT_W, 15, integer magnitude width
- FRAC_W, 10, fraction width (LSB weight 2^-10)
- INT_DIGITS, 5, BCD integer digits (must cover 2^INT_W-1)
- FRAC_DIGITS, 3, BCD fraction digits, truncated, not rounded

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block idle, can accept
- in_neg  in  1  sign flag (1 = negative magnitude)
- in_frac  in  1  fraction-present flag
- in_int  in  INT_W  integer magnitude
- in_fbits  in  FRAC_W  fraction bits
- out_valid  out  1  one-cycle result strobe
- out_neg  out  1  registered copy of in_neg
- out_frac  out  1  registered copy of in_frac
- int_bcd  out  4*INT_DIGITS  packed BCD, MS digit in top nibble
- frac_bcd  out  4*FRAC_DIGITS  packed BCD, first decimal place in top nibble

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, out_neg=0, out_frac=0, int_bcd=0, frac_bcd=0, all working registers cleared.
- FSM states: IDLE, INT, FRAC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture all inputs into working registers, clear the BCD accumulator, load the bit counter with INT_W-1, go to INT.
  - in_ready drops in the next cycle.
- INT (INT_W cycles):
  - Each edge: every BCD nibble ≥5 gets +3, then {bcd, int_shift} shifts left by 1.
  - When the counter reaches 0, go to FRAC with the digit counter at FRAC_DIGITS-1.
- FRAC (FRAC_DIGITS cycles):
  - Each edge: P = F*10 (FRAC_W+4 bits).
  - Append P[FRAC_W+3:FRAC_W] as the next fraction digit; F <= P[FRAC_W-1:0].
  - When the counter reaches 0, go to DONE.
- DONE:
  - On entry edge, load int_bcd, frac_bcd, out_neg and out_frac from working registers; out_valid=1 for exactly one cycle.
  - Next edge: go to IDLE, out_valid=0.
- Latency: out_valid is high in the 19th cycle after the accepting edge (1 + INT_W + FRAC_DIGITS). Throughput: one word per 20 cycles.
- Outputs hold their last result until the next DONE; they are not cleared in IDLE.
- in_valid while not IDLE is ignored and not queued; a word is accepted only when in_ready=1.
- in_valid held high continuously: a new word is accepted on the edge that enters IDLE+1, i.e. the first edge with in_ready=1.
- Fraction digits are computed from in_fbits regardless of in_frac; in_frac is passed through only.
- Zero inputs produce all-zero BCD.
- Max inputs (32767, 1023) produce 0x32767 and 0x999; no overflow is possible.
- Reset asserted mid-conversion aborts it: no out_valid, outputs return to reset values.

Decomposition:
- Shared package fixed_pkg holds:
  - INT_W, FRAC_W, INT_DIGITS, FRAC_DIGITS constants
  - state enum (IDLE/INT/FRAC/DONE)
  - packed BCD vector typedefs
- One combinational sub-module, bcd_add3: 4-bit nibble in, nibble+3 if ≥5 out. Instantiated INT_DIGITS times.

Test Plan:
- Reset check: hold rst_n low, then release -> in_ready=1, out_valid=0, int_bcd=0x00000, frac_bcd=0x000.
- Basic conversion: in_int=12345, in_fbits=512, in_neg=0, in_frac=1 -> 19 cycles later out_valid=1 for one cycle, int_bcd=0x12345, frac_bcd=0x500, out_frac=1.
- Maximum values: in_int=32767, in_fbits=1023, in_neg=1 -> int_bcd=0x32767, frac_bcd=0x999, out_neg=1.
- Fraction truncation: in_int=0, in_fbits=102 -> int_bcd=0x00000, frac_bcd=0x099 (not 0x100).
- Busy handling: in_valid held high with a changing word each cycle -> words accepted exactly 20 cycles apart, each result matches the word captured at acceptance, intermediate words ignored.
- Reset mid-conversion: pull rst_n low at cycle 8 of a conversion -> immediate reset values, no out_valid. A new word after release converts correctly.
